// File: rtl/serial_adder_pkg.sv
// Shared types and sizing for the nibble-serial 16-bit adder.
package serial_adder_pkg;
    localparam int NIBBLE_W    = 4;
    localparam int NUM_NIBBLES = 4;
    localparam int CNT_W       = $clog2(NUM_NIBBLES);
    localparam int DATA_W      = NIBBLE_W * NUM_NIBBLES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/adder_slice_4_bit.sv
// Combinational 4-bit add slice, reused once per nibble by the serial adder.
module adder_slice_4_bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);
    assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {4'b0, Cin};
endmodule

// File: rtl/serial_adder_16_bit.sv
// 16-bit adder computing one nibble per cycle through a single 4-bit slice.
// Optional subtract mode (Sub input) when SERIAL_ADDER_SUB_EN is defined.
module serial_adder_16_bit
    import serial_adder_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic              Sub,
`endif
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Sum,
    output logic              Cout
);
    state_t              state, state_nx;
    logic [DATA_W-1:0]   a_q, b_q, psum, psum_nx;
    logic [CNT_W-1:0]    cnt;
    logic                carry;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;
    logic [DATA_W-1:0]   b_in;
    logic                cin_in;
    logic                last;

    // Subtraction is A + ~B + 1, folded in at capture time.
    always_comb begin
        b_in   = B;
        cin_in = Cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (Sub) begin
            b_in   = ~B;
            cin_in = 1'b1;
        end
`endif
    end

    adder_slice_4_bit u_slice (
        .A    (a_q[cnt*NIBBLE_W +: NIBBLE_W]),
        .B    (b_q[cnt*NIBBLE_W +: NIBBLE_W]),
        .Cin  (carry),
        .Sum  (slice_sum),
        .Cout (slice_cout)
    );

    assign last = (cnt == CNT_W'(NUM_NIBBLES - 1));

    always_comb begin
        psum_nx = psum;
        psum_nx[cnt*NIBBLE_W +: NIBBLE_W] = slice_sum;
    end

    always_comb begin
        state_nx = state;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (state)
            IDLE: if (Start) state_nx = RUN;
            RUN: begin
                Busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                Busy     = 1'b1;
                Done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            psum  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (Start) begin
                    a_q   <= A;
                    b_q   <= b_in;
                    carry <= cin_in;
                    cnt   <= '0;
                    psum  <= '0;
                end
                RUN: begin
                    psum  <= psum_nx;
                    carry <= slice_cout;
                    cnt   <= cnt + 1'b1;
                    // Results are published only on the final nibble.
                    if (last) begin
                        Sum  <= psum_nx;
                        Cout <= slice_cout;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_16_bit.sv
// Randomized self-checking bench for serial_adder_16_bit against a timing/arith model.
module tb_serial_adder_16_bit;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [15:0] A = '0, B = '0;
    logic        Cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic        Sub = 1'b0;
`endif
    logic        Busy, Done, Cout;
    logic [15:0] Sum;

    int checks = 0;
    int errors = 0;

    // model state
    int          cyc = 0;
    bit          active = 0;
    int          acc_at = -100;
    logic [16:0] pend = '0;
    logic [15:0] exp_sum = '0;
    logic        exp_cout = 1'b0;
    int          done_cnt = 0;
    int          busy_cnt = 0;

    serial_adder_16_bit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub   (Sub),
`endif
        .Busy  (Busy),
        .Done  (Done),
        .Sum   (Sum),
        .Cout  (Cout)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Operation accepted at edge t: result published at edge t+4, idle again at t+5.
    task automatic model_edge(input logic st, input logic [15:0] a, input logic [15:0] b,
                              input logic ci, input logic sb, input logic rs);
        if (rs) begin
            active   = 0;
            exp_sum  = '0;
            exp_cout = 1'b0;
        end else if (active && cyc == acc_at + 4) begin
            exp_sum  = pend[15:0];
            exp_cout = pend[16];
        end else if (active && cyc == acc_at + 5) begin
            active = 0;
        end else if (!active && st) begin
            active = 1;
            acc_at = cyc;
            if (sb) pend = {1'b0, a} + {1'b0, ~b} + 17'd1;
            else    pend = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        end
    endtask

    task automatic step(input logic st, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb, input logic rs);
        logic sb_eff;
        sb_eff = 1'b0;
        Start = st; A = a; B = b; Cin = ci; Reset = rs;
`ifdef SERIAL_ADDER_SUB_EN
        Sub = sb;
        sb_eff = sb;
`endif
        @(posedge Clk);
        cyc++;
        model_edge(st, a, b, ci, sb_eff, rs);
        @(negedge Clk);
        chk("busy", Busy, active);
        chk("done", Done, active && cyc == acc_at + 4);
        chk("sum",  Sum,  exp_sum);
        chk("cout", Cout, exp_cout);
        if (Done) done_cnt++;
        if (Busy) busy_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic op(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
        step(1'b1, a, b, ci, sb, 1'b0);
        // operands scrambled while running; Start also pulsed to test it is ignored
        for (int i = 0; i < 5; i++)
            step(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    endtask

    initial begin
        @(negedge Clk);
        step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_sum", Sum, 16'h0000);
        idle(2);

        busy_cnt = 0; done_cnt = 0;
        step(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0);
        idle(6);
        chk("basic_sum", Sum, 16'h5556);
        chk("basic_cout", Cout, 1'b0);
        chk("basic_busy_cycles", busy_cnt, 5);
        chk("basic_done_pulses", done_cnt, 1);

        op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        idle(1);
        chk("ripple_sum", Sum, 16'h0000);
        chk("ripple_cout", Cout, 1'b1);
        op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        idle(1);
        chk("max_sum", Sum, 16'hFFFF);
        chk("max_cout", Cout, 1'b1);

        // continuous Start: one operation per 6 cycles
        done_cnt = 0;
        for (int i = 0; i < 30; i++)
            step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b0);
        chk("held_start_ops", done_cnt, 5);
        idle(6);

        // abort during RUN
        done_cnt = 0;
        step(1'b1, 16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("abort_busy", Busy, 1'b0);
        chk("abort_sum", Sum, 16'h0000);
        op(16'h00FF, 16'h0001, 1'b0, 1'b0);
        chk("abort_done_pulses", done_cnt, 1);
        chk("after_abort_sum", Sum, 16'h0100);
        chk("after_abort_cout", Cout, 1'b0);
        idle(2);

`ifdef SERIAL_ADDER_SUB_EN
        op(16'h0005, 16'h0007, 1'b0, 1'b1);
        chk("sub_neg_sum", Sum, 16'hFFFE);
        chk("sub_neg_cout", Cout, 1'b0);
        op(16'h0007, 16'h0005, 1'b0, 1'b1);
        chk("sub_pos_sum", Sum, 16'h0002);
        chk("sub_pos_cout", Cout, 1'b1);
        op(16'h1234, 16'h4321, 1'b1, 1'b0);
        chk("sub0_sum", Sum, 16'h5556);
`endif

        // random traffic with occasional resets
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 2) == 0), 16'($urandom), 16'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom_range(0, 60) == 0));
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/serial_adder_16_bit.md
SERIAL_ADDER_16_BIT -- requirements
Module: serial_adder_16_bit

Interface
REQ-001 Parameters: none; width fixed at 16 bits, processed as four 4-bit nibbles.
REQ-002 Clk  input  1  single clock, all state on rising edge; reset is synchronous and active-high.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request to add; sampled only in IDLE.
REQ-005 A  input  16  operand A; captured when Start is accepted.
REQ-006 B  input  16  operand B; captured when Start is accepted.
REQ-007 Cin  input  1  carry-in to nibble 0; captured when Start is accepted.
REQ-008 Busy  output  1  high in RUN and DONE.
REQ-009 Done  output  1  one-cycle pulse; Sum/Cout valid.
REQ-010 Sum  output  16  registered result, held until the next result.
REQ-011 Cout  output  1  registered carry-out of nibble 3, held with Sum.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
- IDLE->RUN on Start=1.
- RUN->DONE after the 4th nibble.
- DONE->IDLE unconditionally after one cycle.
REQ-013 On Start acceptance, the block SHALL load A, B and Cin into operand registers, clear the nibble counter and clear the partial-sum register.
REQ-014 Each RUN cycle SHALL add nibble[cnt] of A and B plus the carry register through one 4-bit slice, write the 4-bit result into partial-sum bits [4*cnt+3:4*cnt], store the slice carry-out in the carry register, and increment cnt.
REQ-015 The counter SHALL be 2 bits, counting 0..3, with the RUN->DONE transition taken at cnt=3; it SHALL NOT wrap back into RUN.
REQ-016 Sum and Cout SHALL update only on the RUN->DONE edge; otherwise they SHALL hold their values.
- Sum: full partial sum, including nibble 3.
- Cout: final carry.
REQ-017 Latency: if Start is sampled at edge k, Done SHALL be high during the cycle after edge k+4 and low at all other times.
REQ-018 Start in RUN or DONE SHALL be ignored, neither queued nor restarting the operation.
REQ-019 Changes on A, B or Cin after acceptance SHALL NOT affect the result in progress.
REQ-020 Result SHALL equal (A + B + Cin) mod 2^16, with Cout = bit 16 of the sum.

Reset
REQ-021 Reset=1 at a rising edge SHALL force the following values, overriding Start:
- state = IDLE;
- Busy = 0, Done = 0;
- Sum = 0x0000, Cout = 0;
- cnt, carry, operand and partial-sum registers = 0.
REQ-022 Reset during RUN or DONE SHALL abort the operation with no Done pulse; Start on the first edge after Reset deasserts SHALL be accepted normally.

Configuration
REQ-023 Macro SERIAL_ADDER_SUB_EN, when defined, SHALL add input Sub (1 bit, captured with the operands) that changes the operation as follows:
- Sub=1: B is inverted at capture, Cin is forced to 1, and the result is A - B;
- Cout = 1 means no borrow;
- Sub=0: behaviour identical to the build without the macro.
REQ-024 Without SERIAL_ADDER_SUB_EN, the Sub port and its logic SHALL NOT exist.

Structure
REQ-025 The shared package serial_adder_pkg SHALL hold:
- the state enum typedef (IDLE/RUN/DONE);
- NIBBLE_W=4;
- NUM_NIBBLES=4;
- the counter width.
REQ-026 One combinational sub-module, adder_slice_4_bit, SHALL be instantiated once.
- Ports: A[3:0], B[3:0], Cin, Sum[3:0], Cout.
- The top level holds all sequential logic.

Verification
REQ-027 A=0x1234, B=0x4321, Cin=1, Start pulse -> Done 5 cycles later, Sum=0x5556, Cout=0, Busy high for 5 cycles.
REQ-028 A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1, confirming carry ripple across all 4 nibble boundaries; A=0xFFFF, B=0xFFFF, Cin=1 -> Sum=0xFFFF, Cout=1.
REQ-029 Start=1 held continuously with new A/B applied each cycle -> one operation per 6 cycles, each using operands sampled at its acceptance edge; mid-run changes ignored.
REQ-030 Reset asserted 2 cycles into RUN -> no Done pulse, Sum=0x0000, Busy=0 next cycle; then a fresh Start with 0x00FF+0x0001 -> Sum=0x0100, Cout=0.
REQ-031 With SERIAL_ADDER_SUB_EN: Sub=1, A=0x0005, B=0x0007 -> Sum=0xFFFE, Cout=0; Sub=1, A=0x0007, B=0x0005 -> Sum=0x0002, Cout=1.
REQ-032 Sum/Cout SHALL remain stable from Done until the next RUN->DONE edge; the bench checks every cycle in IDLE.
